mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single owner of the byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - the instruction fetcher, which issues multi-word burst reads into the icache;
  - the load/store buffer (LSB), which issues byte/half/word loads and stores.
- Sequences each transaction byte by byte, accounting for the one-cycle RAM read latency.
- Provides the available/word-done/end handshake the fetcher consumes, and aborts speculative reads on ROB rollback.

Parameters:
- IF_BURST_WORDS, 4, words per fetch burst (1..8).
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- mem_din  input  8  RAM/IO read byte, valid the cycle after its address
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1=write, 0=read
- io_buffer_full  input  1  IO sink cannot accept a write
- if_enable_in  input  1  fetcher burst request (level)
- if_addr_in  input  32  burst start address
- if_available_out  output  1  arbiter can accept a fetch
- if_inst_out  output  32  assembled instruction word
- if_word_done_out  output  1  pulse: non-final burst word valid
- if_end_out  output  1  pulse: final burst word valid, burst over
- lsb_enable_in  input  1  LSB request (level)
- lsb_write_in  input  1  1=store
- lsb_size_in  input  2  0=byte, 1=half, 2=word
- lsb_addr_in  input  32  access address
- lsb_wdata_in  input  32  store data, little-endian
- lsb_rdata_out  output  32  load data, zero-extended
- lsb_done_out  output  1  pulse: access complete
- rollback_in  input  1  ROB misprediction flush

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0.
- rdy_in=0: no state, counter or output register changes, except that mem_wr is forced to 0.
- States:
  - IDLE; IF_READ; LS_READ; LS_WRITE.
  - Byte count k: IF = 4*IF_BURST_WORDS; LS = 1, 2 or 4 per size.
- Arbitration, in IDLE:
  - lsb_enable_in has fixed priority over if_enable_in.
  - Request fields are latched at acceptance (cycle A).
  - No preemption mid-transaction.
- if_available_out = (state==IDLE) && !lsb_enable_in, registered.
- Read timing:
  - mem_a = base+j, mem_wr=0 during cycle A+1+j, for j=0..k-1.
  - Byte j is captured from mem_din in cycle A+2+j, little-endian into byte lane j mod 4.
  - No mem_a driven after the last byte.
- IF burst:
  - Word w is complete after byte 4w+3 is captured.
  - if_inst_out carries word w during cycle A+4w+6.
  - In that cycle, if_word_done_out=1 for w<IF_BURST_WORDS-1; if_end_out=1 for the last word.
  - State returns to IDLE on the same edge that raises if_end_out.
- LS read: lsb_rdata_out valid and lsb_done_out=1 during cycle A+k+2; upper bytes zero; return to IDLE.
- LS write:
  - mem_dout = byte j of lsb_wdata_in, mem_a = base+j, mem_wr=1 during cycle A+1+j.
  - lsb_done_out=1 during A+k+1.
- IO stall: when io_buffer_full=1 and addr[17:16]==IO_ADDR_HI, the write byte is not issued (mem_wr=0) and the counter holds. The transaction resumes the cycle after io_buffer_full drops.
- Rollback:
  - IF_READ or LS_READ: abort; next state IDLE; no done/end pulse; in-flight bytes discarded.
  - LS_WRITE: not aborted (stores are committed); completes normally.
  - IDLE: a request sampled in the same cycle as rollback_in is not accepted.
- Pulses (if_word_done_out, if_end_out, lsb_done_out) are exactly one cycle wide.
- Back-to-back: the earliest next acceptance is the cycle after the transaction returns to IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Reset asserted mid-transaction: everything returns to reset values on that edge; no pulse is emitted.

Test Plan:
- Fetch only, if_addr_in=0x100, RAM holds words 0x11111111,0x22222222,0x33333333,0x44444444 -> mem_a steps 0x100..0x10F. if_word_done_out pulses with 0x11111111, 0x22222222, 0x33333333 at A+6, A+10, A+14. if_end_out pulses with 0x44444444 at A+18.
- Simultaneous IF and LSB byte load at 0x2003 (mem=0xFE) in IDLE -> LSB served first; lsb_rdata_out=0x000000FE, lsb_done_out at A+3. if_available_out stays 0 until the LSB transaction ends, then the IF burst starts.
- Word store 0xDEADBEEF to 0x40 -> bytes EF, BE, AD, DE with mem_wr=1 at 0x40..0x43; lsb_done_out at A+5.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write; lsb_done_out one cycle later.
- rollback_in during byte 6 of an IF burst -> no further mem_a issued, no if_word_done_out/if_end_out, state IDLE, if_available_out=1 next cycle.
- rdy_in low for 5 cycles mid half-load -> mem_a and counter frozen; result identical to the unstalled case, shifted by 5 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: LSB loads/stores take priority over
// instruction-fetch bursts, sequenced byte by byte with one-cycle read latency.
module mem_arbiter #(
  parameter int         IF_BURST_WORDS = 4,
  parameter logic [1:0] IO_ADDR_HI     = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_enable_in,
  input  logic [31:0] if_addr_in,
  output logic        if_available_out,
  output logic [31:0] if_inst_out,
  output logic        if_word_done_out,
  output logic        if_end_out,
  input  logic        lsb_enable_in,
  input  logic        lsb_write_in,
  input  logic [1:0]  lsb_size_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_wdata_in,
  output logic [31:0] lsb_rdata_out,
  output logic        lsb_done_out,
  input  logic        rollback_in
);

  typedef enum logic [1:0] {
    IDLE, IF_READ, LS_READ, LS_WRITE
  } state_e;

  localparam logic [5:0] IF_K = 6'(4 * IF_BURST_WORDS);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  cap_q, cap_d;
  logic [5:0]  k_q, k_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wdone_q, wdone_d;
  logic        end_q, end_d;
  logic        done_q, done_d;
  logic        avail_q, avail_d;

  logic [31:0] issue_addr;
  logic [31:0] cap_addr;
  logic [31:0] merged;
  logic [7:0]  wbyte;
  logic        io_stall;
  logic        pend;

  assign issue_addr = base_q + {26'd0, cnt_q};
  assign cap_addr   = base_q + {26'd0, cap_q};
  assign io_stall   = io_buffer_full &&
                      (issue_addr[17:16] == IO_ADDR_HI);
  assign pend       = (cap_q < cnt_q);

  always_comb begin
    merged = buf_q;
    unique case (cap_q[1:0])
      2'd0: merged[7:0]   = mem_din;
      2'd1: merged[15:8]  = mem_din;
      2'd2: merged[23:16] = mem_din;
      2'd3: merged[31:24] = mem_din;
    endcase
    unique case (cnt_q[1:0])
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    k_d      = k_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    wdone_d  = 1'b0;
    end_d    = 1'b0;
    done_d   = 1'b0;
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rollback_in && lsb_enable_in) begin
          base_d  = lsb_addr_in;
          wdata_d = lsb_wdata_in;
          cnt_d   = 6'd0;
          cap_d   = 6'd0;
          buf_d   = 32'd0;
          unique case (lsb_size_in)
            2'd0:    k_d = 6'd1;
            2'd1:    k_d = 6'd2;
            default: k_d = 6'd4;
          endcase
          state_d = lsb_write_in ? LS_WRITE : LS_READ;
        end else if (!rollback_in && if_enable_in) begin
          base_d  = if_addr_in;
          cnt_d   = 6'd0;
          cap_d   = 6'd0;
          buf_d   = 32'd0;
          k_d     = IF_K;
          state_d = IF_READ;
        end
      end
      IF_READ, LS_READ: begin
        if (rollback_in) begin
          state_d = IDLE;
        end else begin
          if (cnt_q < k_q) begin
            mem_a = issue_addr;
            cnt_d = cnt_q + 6'd1;
          end
          if (pend) begin
            buf_d = merged;
            cap_d = cap_q + 6'd1;
            if (state_q == IF_READ) begin
              if (cap_q[1:0] == 2'd3) begin
                inst_d = merged;
                if (cap_q + 6'd1 == k_q) begin
                  end_d   = 1'b1;
                  state_d = IDLE;
                end else begin
                  wdone_d = 1'b1;
                end
              end
            end else if (cap_q + 6'd1 == k_q) begin
              rdata_d = merged;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      LS_WRITE: begin
        mem_a    = issue_addr;
        mem_dout = wbyte;
        if (!io_stall) begin
          mem_wr = 1'b1;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == k_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    avail_d = (state_d == IDLE) && !lsb_enable_in;
    // While frozen, re-present the byte awaiting capture so mem_din holds it on resume
    if (!rdy_in) begin
      mem_wr = 1'b0;
      if ((state_q == IF_READ || state_q == LS_READ) && pend)
        mem_a = cap_addr;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      cap_q   <= 6'd0;
      k_q     <= 6'd0;
      base_q  <= 32'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
      inst_q  <= 32'd0;
      rdata_q <= 32'd0;
      wdone_q <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      avail_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      k_q     <= k_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
      wdone_q <= wdone_d;
      end_q   <= end_d;
      done_q  <= done_d;
      avail_q <= avail_d;
    end
  end

  assign if_available_out = avail_q;
  assign if_inst_out      = inst_q;
  assign if_word_done_out = wdone_q;
  assign if_end_out       = end_q;
  assign lsb_rdata_out    = rdata_q;
  assign lsb_done_out     = done_q;

endmodule
